// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port word RAM between the CPU and a debug/loader port.
// Debug has priority, capped by a fairness counter; a lock mode gives the loader exclusive access.
module mem_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 16,
  parameter int MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [1:0]        dbg_be,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic              ram_en,
  output logic              ram_we,
  output logic [1:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_e;

  localparam logic [3:0] CNT_MAX = 4'(MAX_CONSEC);

  owner_e            r_rd_owner;
  logic [3:0]        r_cnt;
  logic              r_lock_active;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  owner_e            w_winner;
  logic              w_lock;
  logic              w_read;

  // Lock releases in the very cycle dbg_lock drops, so that cycle arbitrates normally.
  assign w_lock = r_lock_active & dbg_lock;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_winner = OWN_NONE;
    if (rst) begin
      w_winner = OWN_NONE;
    end else if (w_lock) begin
      if (dbg_req) w_winner = OWN_DBG;
    end else if (dbg_req && cpu_req && (r_cnt == CNT_MAX)) begin
      w_winner = OWN_CPU;
    end else if (dbg_req) begin
      w_winner = OWN_DBG;
    end else if (cpu_req) begin
      w_winner = OWN_CPU;
    end
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 2'b00;
    ram_addr  = '0;
    ram_wdata = '0;
    case (w_winner)
      OWN_CPU: begin
        ram_en    = 1'b1;
        ram_we    = cpu_we;
        ram_be    = cpu_we ? cpu_be : 2'b11;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      OWN_DBG: begin
        ram_en    = 1'b1;
        ram_we    = dbg_we;
        ram_be    = dbg_we ? dbg_be : 2'b11;
        ram_addr  = dbg_addr;
        ram_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_gnt = (w_winner == OWN_CPU);
  assign dbg_gnt = (w_winner == OWN_DBG);
  assign w_read  = ram_en & ~ram_we;

  // NOTE: state uses non-blocking assignments and is cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_owner    <= OWN_NONE;
      r_cnt         <= 4'd0;
      r_lock_active <= 1'b0;
      r_cpu_rdata   <= '0;
      r_dbg_rdata   <= '0;
    end else begin
      if (dbg_gnt && dbg_lock) begin
        r_lock_active <= 1'b1;
      end else if (!dbg_lock) begin
        r_lock_active <= 1'b0;
      end

      if (w_lock || !cpu_req || cpu_gnt) begin
        r_cnt <= 4'd0;
      end else if (dbg_gnt && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 4'd1;
      end

      r_rd_owner <= w_read ? w_winner : OWN_NONE;

      if (r_rd_owner == OWN_CPU) r_cpu_rdata <= ram_rdata;
      if (r_rd_owner == OWN_DBG) r_dbg_rdata <= ram_rdata;
    end
  end

  // RAM data is presented during the rvalid cycle and held afterwards in the port register.
  assign cpu_rvalid = (r_rd_owner == OWN_CPU);
  assign dbg_rvalid = (r_rd_owner == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : r_cpu_rdata;
  assign dbg_rdata  = dbg_rvalid ? ram_rdata : r_dbg_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM, shadow memory model and read-return scoreboard.
module tb_mem_arbiter;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 16;
  localparam int MAX_CONSEC = 4;

  typedef struct {
    logic        is_dbg;
    logic [15:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [1:0]        cpu_be = 2'b00;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [1:0]        dbg_be = 2'b00;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [DATA_W-1:0] dbg_wdata = '0;
  logic              dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              ram_en, ram_we;
  logic [1:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  logic [15:0] ram       [32] = '{default: 16'h0000};
  logic [15:0] model_mem [32] = '{default: 16'h0000};
  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CONSEC(MAX_CONSEC)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_be(dbg_be), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        if (ram_be[1]) ram[ram_addr][15:8] <= ram_wdata[15:8];
        if (ram_be[0]) ram[ram_addr][7:0]  <= ram_wdata[7:0];
      end else begin
        ram_rdata <= ram[ram_addr];
      end
    end
  end

  task automatic set_cpu(input logic req, input logic we, input logic [1:0] be,
                         input logic [4:0] addr, input logic [15:0] wdata);
    cpu_req = req; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [1:0] be,
                         input logic [4:0] addr, input logic [15:0] wdata, input logic lock);
    dbg_req = req; dbg_we = we; dbg_be = be; dbg_addr = addr; dbg_wdata = wdata; dbg_lock = lock;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [1:0] be,
                                        input logic [15:0] d);
    logic [15:0] r;
    r = old;
    if (be[1]) r[15:8] = d[15:8];
    if (be[0]) r[7:0]  = d[7:0];
    return r;
  endfunction

  // Waits for the falling edge, retires the read due this cycle and records this cycle's grant.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      sb_q.delete();
    end else begin
      if (cpu_rvalid || dbg_rvalid) begin
        checks++;
        if (sb_q.size() == 0 || (cpu_rvalid && dbg_rvalid)) begin
          errors++;
          $display("FAIL sb_rvalid: cpu_rvalid=%0b dbg_rvalid=%0b outstanding=%0d, required one rvalid per granted read",
                   cpu_rvalid, dbg_rvalid, sb_q.size());
        end else begin
          e = sb_q.pop_front();
          if (dbg_rvalid !== e.is_dbg || (e.is_dbg ? dbg_rdata : cpu_rdata) !== e.data) begin
            errors++;
            $display("FAIL sb_rdata: port_dbg=%0b data=%h, required port_dbg=%0b data=%h",
                     dbg_rvalid, e.is_dbg ? dbg_rdata : cpu_rdata, e.is_dbg, e.data);
          end
        end
      end else if (sb_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL sb_missing: no rvalid, required rvalid port_dbg=%0b data=%h",
                 sb_q[0].is_dbg, sb_q[0].data);
        sb_q.delete(0);
      end
      if (cpu_gnt && dbg_gnt) begin
        checks++;
        errors++;
        $display("FAIL sb_double_gnt: cpu_gnt=1 dbg_gnt=1, required at most one grant");
      end
      if (cpu_gnt) begin
        if (cpu_we) model_mem[cpu_addr] = merge(model_mem[cpu_addr], cpu_be, cpu_wdata);
        else sb_q.push_back('{is_dbg: 1'b0, data: model_mem[cpu_addr]});
      end else if (dbg_gnt) begin
        if (dbg_we) model_mem[dbg_addr] = merge(model_mem[dbg_addr], dbg_be, dbg_wdata);
        else sb_q.push_back('{is_dbg: 1'b1, data: model_mem[dbg_addr]});
      end
    end
  endtask

  task automatic do_write(input logic use_dbg, input logic [4:0] addr, input logic [1:0] be,
                          input logic [15:0] d);
    if (use_dbg) set_dbg(1'b1, 1'b1, be, addr, d, 1'b0);
    else         set_cpu(1'b1, 1'b1, be, addr, d);
    sample();
    step();
    set_cpu(1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
    set_dbg(1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
  endtask

  task automatic test_reset();
    set_cpu(1'b1, 1'b0, 2'b00, 5'd3, 16'h0);
    set_dbg(1'b1, 1'b0, 2'b00, 5'd4, 16'h0, 1'b0);
    sample();
    checks++;
    if ({cpu_gnt, dbg_gnt, ram_en, cpu_rvalid, dbg_rvalid} !== 5'b0 || cpu_rdata !== 16'h0 || dbg_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%0b%0b ram_en=%0b rvalid=%0b%0b rdata=%h/%h, required all 0",
               cpu_gnt, dbg_gnt, ram_en, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata);
    end
    set_cpu(1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
    set_dbg(1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    step();
    rst = 1'b0;
    sample();
    checks++;
    if ({ram_en, ram_we, ram_be, ram_addr, ram_wdata} !== '0) begin
      errors++;
      $display("FAIL idle_ram: en=%0b we=%0b be=%b addr=%0d wdata=%h, required all 0",
               ram_en, ram_we, ram_be, ram_addr, ram_wdata);
    end
    step();
  endtask

  task automatic test_uncontended_read();
    do_write(1'b0, 5'd3, 2'b11, 16'hA55A);
    set_cpu(1'b1, 1'b0, 2'b00, 5'd3, 16'h0);
    sample();
    checks++;
    if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || ram_en !== 1'b1 || ram_we !== 1'b0 ||
        ram_addr !== 5'd3 || ram_be !== 2'b11) begin
      errors++;
      $display("FAIL unc_grant: gnt=%0b%0b en=%0b we=%0b addr=%0d be=%b, required cpu grant read addr 3 be 11",
               cpu_gnt, dbg_gnt, ram_en, ram_we, ram_addr, ram_be);
    end
    step();
    set_cpu(1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
    sample();
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hA55A || dbg_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL unc_rvalid: cpu_rvalid=%0b cpu_rdata=%h dbg_rvalid=%0b, required 1 A55A 0",
               cpu_rvalid, cpu_rdata, dbg_rvalid);
    end
    step();
    sample();
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'hA55A) begin
      errors++;
      $display("FAIL unc_hold: cpu_rvalid=%0b cpu_rdata=%h, required 0 A55A", cpu_rvalid, cpu_rdata);
    end
    step();
  endtask

  task automatic test_byte_lanes();
    do_write(1'b1, 5'd7, 2'b11, 16'h3344);
    set_dbg(1'b1, 1'b1, 2'b10, 5'd7, 16'h12FF, 1'b0);
    sample();
    checks++;
    if (dbg_gnt !== 1'b1 || ram_we !== 1'b1 || ram_be !== 2'b10 || ram_addr !== 5'd7 || ram_wdata !== 16'h12FF) begin
      errors++;
      $display("FAIL be_write: gnt=%0b we=%0b be=%b addr=%0d wdata=%h, required 1 1 10 7 12FF",
               dbg_gnt, ram_we, ram_be, ram_addr, ram_wdata);
    end
    step();
    set_dbg(1'b1, 1'b0, 2'b00, 5'd7, 16'h0, 1'b0);
    sample();
    step();
    set_dbg(1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    sample();
    checks++;
    if (dbg_rvalid !== 1'b1 || dbg_rdata !== 16'h1244) begin
      errors++;
      $display("FAIL be_readback: dbg_rvalid=%0b dbg_rdata=%h, required 1 1244", dbg_rvalid, dbg_rdata);
    end
    step();
    set_dbg(1'b1, 1'b1, 2'b00, 5'd7, 16'hFFFF, 1'b0);
    sample();
    checks++;
    if (dbg_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b1 || ram_be !== 2'b00) begin
      errors++;
      $display("FAIL be_zero: gnt=%0b en=%0b we=%0b be=%b, required 1 1 1 00", dbg_gnt, ram_en, ram_we, ram_be);
    end
    step();
    set_dbg(1'b1, 1'b0, 2'b00, 5'd7, 16'h0, 1'b0);
    sample();
    step();
    set_dbg(1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    sample();
    checks++;
    if (dbg_rdata !== 16'h1244) begin
      errors++;
      $display("FAIL be_zero_readback: dbg_rdata=%h, required 1244", dbg_rdata);
    end
    step();
  endtask

  task automatic test_fairness();
    logic exp_cpu;
    set_cpu(1'b1, 1'b0, 2'b00, 5'd1, 16'h0);
    set_dbg(1'b1, 1'b0, 2'b00, 5'd2, 16'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      sample();
      exp_cpu = ((i % (MAX_CONSEC + 1)) == MAX_CONSEC);
      checks++;
      if (cpu_gnt !== exp_cpu || dbg_gnt !== !exp_cpu) begin
        errors++;
        $display("FAIL fair_seq[%0d]: cpu_gnt=%0b dbg_gnt=%0b, required cpu_gnt=%0b", i, cpu_gnt, dbg_gnt, exp_cpu);
      end
      step();
    end
    set_cpu(1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
    set_dbg(1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    sample();
    step();
  endtask

  task automatic test_lock();
    set_cpu(1'b1, 1'b0, 2'b00, 5'd3, 16'h0);
    set_dbg(1'b1, 1'b0, 2'b00, 5'd7, 16'h0, 1'b1);
    sample();
    checks++;
    if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL lock_take: dbg_gnt=%0b cpu_gnt=%0b, required 1 0", dbg_gnt, cpu_gnt);
    end
    step();
    set_dbg(1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      sample();
      checks++;
      if (cpu_gnt !== 1'b0 || ram_en !== 1'b0) begin
        errors++;
        $display("FAIL lock_hold[%0d]: cpu_gnt=%0b ram_en=%0b, required 0 0", i, cpu_gnt, ram_en);
      end
      step();
    end
    dbg_lock = 1'b0;
    sample();
    checks++;
    if (cpu_gnt !== 1'b1 || ram_addr !== 5'd3) begin
      errors++;
      $display("FAIL lock_release: cpu_gnt=%0b ram_addr=%0d, required 1 3", cpu_gnt, ram_addr);
    end
    step();
    set_cpu(1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
    sample();
    step();
  endtask

  task automatic test_interleaved();
    do_write(1'b0, 5'd1, 2'b11, 16'h1111);
    do_write(1'b1, 5'd2, 2'b11, 16'h2222);
    set_cpu(1'b1, 1'b0, 2'b00, 5'd1, 16'h0);
    sample();
    step();
    set_cpu(1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
    set_dbg(1'b1, 1'b0, 2'b00, 5'd2, 16'h0, 1'b0);
    sample();
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1111 || dbg_gnt !== 1'b1 || dbg_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL il_first: cpu_rvalid=%0b cpu_rdata=%h dbg_gnt=%0b dbg_rvalid=%0b, required 1 1111 1 0",
               cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid);
    end
    step();
    set_dbg(1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    sample();
    checks++;
    if (dbg_rvalid !== 1'b1 || dbg_rdata !== 16'h2222 || cpu_rvalid !== 1'b0 || cpu_rdata !== 16'h1111) begin
      errors++;
      $display("FAIL il_second: dbg_rvalid=%0b dbg_rdata=%h cpu_rvalid=%0b cpu_rdata=%h, required 1 2222 0 1111",
               dbg_rvalid, dbg_rdata, cpu_rvalid, cpu_rdata);
    end
    step();
    sample();
    checks++;
    if (dbg_rdata !== 16'h2222 || cpu_rdata !== 16'h1111) begin
      errors++;
      $display("FAIL il_hold: dbg_rdata=%h cpu_rdata=%h, required 2222 1111", dbg_rdata, cpu_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [4:0] addrs [6] = '{5'd3, 5'd7, 5'd1, 5'd4, 5'd4, 5'd4};
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        set_cpu(1'b1, 1'b0, 2'b00, addrs[i], 16'h0);
        set_dbg(1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
      end else begin
        set_cpu(1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
        set_dbg(1'b1, (i == 3), 2'b11, addrs[i], 16'h4444, 1'b0);
      end
      sample();
      checks++;
      if (cpu_gnt !== (i % 2 == 0) || dbg_gnt !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL b2b_gnt[%0d]: cpu_gnt=%0b dbg_gnt=%0b, required cpu_gnt=%0b", i, cpu_gnt, dbg_gnt, (i % 2 == 0));
      end
      step();
    end
    set_cpu(1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
    set_dbg(1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    sample();
    step();
  endtask

  task automatic test_reset_mid_read();
    set_cpu(1'b1, 1'b0, 2'b00, 5'd3, 16'h0);
    sample();
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rmr_gnt: cpu_gnt=%0b, required 1", cpu_gnt);
    end
    #2 rst = 1'b1;
    step();
    sample();
    checks++;
    if ({cpu_gnt, dbg_gnt, ram_en, cpu_rvalid, dbg_rvalid} !== 5'b0 || cpu_rdata !== 16'h0 || dbg_rdata !== 16'h0) begin
      errors++;
      $display("FAIL rmr_outputs: gnt=%0b%0b en=%0b rvalid=%0b%0b rdata=%h/%h, required all 0",
               cpu_gnt, dbg_gnt, ram_en, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata);
    end
    set_cpu(1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
    step();
    rst = 1'b0;
    sample();
    step();
    // Build the fairness count to its cap, then reset before the CPU would win.
    set_cpu(1'b1, 1'b0, 2'b00, 5'd1, 16'h0);
    set_dbg(1'b1, 1'b0, 2'b00, 5'd2, 16'h0, 1'b0);
    for (int i = 0; i < MAX_CONSEC; i++) begin
      sample();
      step();
    end
    #1 rst = 1'b1;
    sample();
    step();
    rst = 1'b0;
    sample();
    checks++;
    if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rmr_cnt_cleared: dbg_gnt=%0b cpu_gnt=%0b, required 1 0", dbg_gnt, cpu_gnt);
    end
    step();
    set_cpu(1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
    set_dbg(1'b0, 1'b0, 2'b00, 5'd0, 16'h0, 1'b0);
    sample();
    step();
  endtask

  initial begin
    step();
    test_reset();
    test_uncontended_read();
    test_byte_lanes();
    test_fairness();
    test_lock();
    test_interleaved();
    test_back_to_back();
    test_reset_mid_read();
    repeat (2) begin
      sample();
      step();
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: outstanding reads=%0d, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the CPU's single-port 16-bit word RAM between the CPU memory port (fetch/load/store) and a debug/program-loader port. It grants at most one access per cycle, drives the RAM, and routes the one-cycle-latency read data back to the granted requester. Debug has priority, but a fairness cap guarantees the CPU forward progress. A lock mode gives the loader exclusive RAM ownership for bulk program download.

## Interface
- ADDR_W, 5: word address width (32 words).
- DATA_W, 16: RAM word width; must be 16 (two byte lanes).
- MAX_CONSEC, 4: max back-to-back debug grants while cpu_req is pending; range 1..15.

Reset and clock: rst is asynchronous, active-high; the clock is clk.

- clk  in  1  clock
- rst  in  1  async active-high reset
- cpu_req  in  1  CPU access request; held with its fields stable until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_be  in  2  write byte enables; [1] = bits 15:8, [0] = bits 7:0; ignored on reads
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  16  write data
- cpu_gnt  out  1  request accepted this cycle (combinational)
- cpu_rvalid  out  1  read data valid (registered)
- cpu_rdata  out  16  read data; held between rvalids
- dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* set, for the debug port
- dbg_lock  in  1  request exclusive ownership (sampled on dbg grant)
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write
- ram_be  out  2  RAM byte lanes
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  16  RAM write data
- ram_rdata  in  16  RAM read data, valid the cycle after ram_en with ram_we=0

## Operation
- Winner selection, evaluated each cycle:
  - If lock_active=1: debug wins if dbg_req=1; otherwise there is no winner. CPU is never granted.
  - Else if dbg_req=1 and cpu_req=1 and cnt==MAX_CONSEC: CPU wins.
  - Else if dbg_req=1: debug wins.
  - Else if cpu_req=1: CPU wins.
- Winner's gnt=1 and ram_en=1. ram_we, ram_be, ram_addr and ram_wdata are muxed from the winner.
- With no winner: ram_en=0, ram_we=0, ram_be=0, ram_addr=0, ram_wdata=0.
- ram_be is forced to 2'b11 on reads. A write with be=2'b00 is still granted and presented (ram_we=1, ram_be=0) with no data effect.
- Fairness counter cnt (4 bits):
  - Increments on a debug grant while cpu_req=1 and lock_active=0.
  - Saturates at MAX_CONSEC.
  - Clears on a CPU grant, on any cycle with cpu_req=0, and whenever lock_active=1.
- Lock state:
  - lock_active sets on a debug grant with dbg_lock=1.
  - It clears on the first cycle with dbg_lock=0; normal arbitration applies in that same cycle.
- Read return:
  - Register rd_owner (none/cpu/dbg) captures the winner of a granted read.
  - The next cycle, that port's rvalid=1 and its rdata is loaded from ram_rdata. The other port's rdata is unchanged.
  - Writes produce no rvalid.
- Reset:
  - All gnt=0, rvalid=0, rdata=0.
  - cnt=0, lock_active=0, rd_owner=none.
  - A read granted in the cycle before reset asserts produces no rvalid.

## Timing
- Uncontended latency: gnt in the same cycle as req; rvalid exactly 1 cycle after gnt.
- Back-to-back grants are allowed every cycle, including alternating ports.
- A read rvalid and a new grant may occur in the same cycle.
- Requesters must not change req fields while req=1 and gnt=0. Deasserting req before gnt is permitted; no access occurs.
- Worst-case CPU wait with lock_active=0 and dbg_req continuously 1: MAX_CONSEC cycles, then granted.
- With lock_active=1 the CPU wait is unbounded; the system relies on the loader dropping dbg_lock.
- The async reset deasserts synchronously to clk.

## Test plan
- **Uncontended read:** CPU read addr 3 with RAM word 3 = 16'hA55A -> cpu_gnt=1 at T, cpu_rvalid=1 and cpu_rdata=16'hA55A at T+1, dbg_rvalid=0 throughout.
- **Byte-lane write:** dbg write addr 7, be=2'b10, wdata=16'h12FF over word 16'h3344 -> ram_be=2'b10, later read returns 16'h1244. be=2'b00 write leaves the word unchanged.
- **Fairness:** cpu_req and dbg_req both held high with MAX_CONSEC=4 -> grant sequence is D,D,D,D,C,D,D,D,D,C. cnt returns to 0 after each CPU grant.
- **Lock:** dbg grant with dbg_lock=1, then dbg_req low for 10 cycles with cpu_req high -> cpu_gnt stays 0 and ram_en stays 0. dbg_lock drops -> cpu_gnt=1 in that same cycle.
- **Interleaved reads:** CPU read addr 1 at T, dbg read addr 2 at T+1 -> cpu_rvalid at T+1 with word 1, dbg_rvalid at T+2 with word 2. No cross-routing; each rdata is held afterwards.
- **Reset mid-read:** assert rst one cycle after a granted CPU read -> no cpu_rvalid, all outputs 0. After reset, a contended request is granted to dbg with cnt=0.
